// File: rtl/uart_rx_bus.sv
// UART receiver with a small byte FIFO and a register interface.
// Register map: 0 = RX data (pops on read), 1 = status / sticky-flag clear,
// 2 = control (bit0 irq_en). Serial format: 8N1, LSB first, idle high.
module uart_rx_bus #(
  parameter int BAUD  = 115200,
  parameter int MHZ   = 25,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        RxD,
  output logic        rx_irq
);

  localparam int CPB = (MHZ * 1000000) / BAUD;
  localparam int TW  = $clog2(CPB) + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [TW-1:0] T_LAST   = TW'(CPB - 1);
  localparam logic [TW-1:0] T_HALF   = TW'(CPB / 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          sync1_q, rxs_q, rxs_prev_q;
  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    shift_q;
  logic [2:0]    bitcnt_q;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovr_q, ferr_q, irq_en_q;

  logic rd_s, wr_s, empty_s, full_s, pop_s, push_s, fe_set_s, wr_en_s, ovr_set_s;
  logic stop_tick_s;
  logic unused_s;

  assign rd_s        = ce & ~we;
  assign wr_s        = ce & we;
  assign empty_s     = (count_q == {CW{1'b0}});
  assign full_s      = (count_q == CNT_FULL);
  assign pop_s       = rd_s && (addr == 3'd0) && !empty_s;
  assign stop_tick_s = (state_q == STOP) && (timer_q == T_LAST);
  assign push_s      = stop_tick_s && rxs_q;
  assign fe_set_s    = stop_tick_s && !rxs_q;
  // A full FIFO still accepts the byte when a pop frees the slot in the same cycle.
  assign wr_en_s     = push_s && (!full_s || pop_s);
  assign ovr_set_s   = push_s && full_s && !pop_s;
  assign unused_s    = &{1'b0, din[31:4], din[1]};

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= RxD;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Receiver FSM: start-bit qualification at mid-bit, then full-bit sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= {TW{1'b0}};
      shift_q  <= 8'h00;
      bitcnt_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rxs_prev_q && !rxs_q) begin
            timer_q <= {TW{1'b0}};
            state_q <= START;
          end
        end
        START: begin
          if (timer_q == T_HALF) begin
            timer_q  <= {TW{1'b0}};
            bitcnt_q <= 3'd0;
            state_q  <= rxs_q ? IDLE : DATA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DATA: begin
          if (timer_q == T_LAST) begin
            timer_q  <= {TW{1'b0}};
            shift_q  <= {rxs_q, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        STOP: begin
          if (timer_q == T_LAST) begin
            timer_q <= {TW{1'b0}};
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          timer_q <= {TW{1'b0}};
          state_q <= IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because reads are gated by count.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wptr_q] <= shift_q;
    end
  end

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy, sticky flags and control register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= {AW{1'b0}};
      rptr_q   <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (wr_en_s) wptr_q <= wptr_q + AW'(1);
      if (pop_s)   rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      // Setting a flag takes priority over a software clear in the same cycle.
      if (ovr_set_s) begin
        ovr_q <= 1'b1;
      end else if (wr_s && (addr == 3'd1) && din[2]) begin
        ovr_q <= 1'b0;
      end
      if (fe_set_s) begin
        ferr_q <= 1'b1;
      end else if (wr_s && (addr == 3'd1) && din[3]) begin
        ferr_q <= 1'b0;
      end
      if (wr_s && (addr == 3'd2)) begin
        irq_en_q <= din[0];
      end
    end
  end

  // Combinational read mux; zero whenever no read is being performed.
  always_comb begin
    dout = 32'h0;
    if (rd_s) begin
      case (addr)
        3'd0:    dout = empty_s ? 32'h0 : {24'h0, mem_q[rptr_q]};
        3'd1:    dout = {23'h0, 5'(count_q), ferr_q, ovr_q, full_s, !empty_s};
        3'd2:    dout = {31'h0, irq_en_q};
        default: dout = 32'h0;
      endcase
    end else begin
      dout = 32'h0;
    end
  end

  assign rx_irq = irq_en_q & !empty_s;

endmodule

// File: tb/tb_uart_rx_bus.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_bus: bus reads queue their expected data,
// a monitor compares dout whenever a read strobe is on the bus.
module tb_uart_rx_bus;

  localparam int CPB = 217;

  logic        clk = 1'b0;
  logic        rst, ce, we, RxD, rx_irq;
  logic [2:0]  addr;
  logic [31:0] din, dout;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  uart_rx_bus #(.BAUD(115200), .MHZ(25), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr),
    .din(din), .dout(dout), .RxD(RxD), .rx_irq(rx_irq)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every read strobe consumes one queued expectation.
  always @(negedge clk) begin
    if (ce === 1'b1 && we === 1'b0) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: addr %0d dout 0x%08h, nothing queued", addr, dout);
      end else begin
        e = sb.pop_front();
        check(e.name, dout, e.val);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
    sb.push_back('{name: name, val: exp});
    @(posedge clk); #1;
    ce = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    ce = 1'b0; addr = 3'd0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    ce = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0; addr = 3'd0; din = 32'h0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int hold_low);
    RxD = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      hold(CPB);
    end
    RxD = stop;
    hold(CPB);
    if (hold_low > 0) begin
      RxD = 1'b0;
      hold(hold_low);
    end
    RxD = 1'b1;
    hold(20);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 3'd0; din = 32'h0; RxD = 1'b1;
    hold(5);
    rst = 1'b0;
    hold(5);

    // Reset state
    check("reset_rx_irq", {31'h0, rx_irq}, 32'h0);
    bus_read(3'd1, 32'h0, "reset_status");
    bus_read(3'd2, 32'h0, "reset_ctrl");
    bus_read(3'd0, 32'h0, "empty_read");

    // Control register and ignored addresses
    bus_write(3'd2, 32'hFFFF_FFFF);
    bus_read(3'd2, 32'h1, "ctrl_rw");
    bus_write(3'd2, 32'h0);
    bus_read(3'd2, 32'h0, "ctrl_clear");
    bus_write(3'd0, 32'hFF);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd7, 32'hFF);
    bus_read(3'd1, 32'h0, "status_after_junk_writes");
    bus_read(3'd5, 32'h0, "addr5_read");

    // Single byte
    send_byte(8'hA5, 1'b1, 0);
    bus_read(3'd1, 32'h11, "a5_status");
    bus_read(3'd0, 32'hA5, "a5_data");
    bus_read(3'd1, 32'h00, "a5_status_after");

    // Overflow: nine bytes into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, 0);
    bus_read(3'd1, 32'h87, "ovr_status");
    for (int i = 1; i <= 8; i++) bus_read(3'd0, 32'(i), "fifo_order");
    bus_read(3'd0, 32'h0, "empty_read_after_drain");
    bus_read(3'd1, 32'h04, "ovr_sticky");
    bus_write(3'd1, 32'h4);
    bus_read(3'd1, 32'h00, "ovr_cleared");

    // Framing error, then the line held low: no further frames
    send_byte(8'h3C, 1'b0, 3000);
    bus_read(3'd1, 32'h08, "ferr_status");
    bus_write(3'd1, 32'h8);
    bus_read(3'd1, 32'h00, "ferr_cleared");

    // Glitch rejection then a good frame
    RxD = 1'b0;
    hold(50);
    RxD = 1'b1;
    hold(300);
    bus_read(3'd1, 32'h00, "glitch_status");
    send_byte(8'h55, 1'b1, 0);
    bus_read(3'd1, 32'h11, "post_glitch_status");
    bus_read(3'd0, 32'h55, "post_glitch_data");

    // Interrupt
    bus_write(3'd2, 32'h1);
    check("irq_idle", {31'h0, rx_irq}, 32'h0);
    send_byte(8'h7E, 1'b1, 0);
    check("irq_raised", {31'h0, rx_irq}, 32'h1);
    bus_read(3'd0, 32'h7E, "irq_data");
    check("irq_dropped", {31'h0, rx_irq}, 32'h0);

    // Reset in the middle of frame 0xFF (irq_en left set to see it cleared)
    RxD = 1'b0;
    hold(CPB);
    RxD = 1'b1;
    hold(CPB * 3);
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(CPB * 7);
    bus_read(3'd1, 32'h00, "midframe_rst_status");
    bus_read(3'd2, 32'h00, "midframe_rst_ctrl");
    send_byte(8'h12, 1'b1, 0);
    bus_read(3'd1, 32'h11, "after_rst_status");
    bus_read(3'd0, 32'h12, "after_rst_data");

    hold(5);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
